multi_channel_sense_filter: RTL and testbench

- Per-channel sense-event qualifier for clks_alot.
- Each channel owns a registered interval counter and classifies every sense event against a shared programmable window: early (over-frequency), in-band, or late (under-frequency/timeout).
- Each channel runs an acquire/lock/fault state machine and forwards only in-band events from locked channels as filtered pulses.
- Sits between edge-sense logic and the rate-recovery/clock-generation blocks.

---
 rtl/multi_channel_sense_filter_pkg.sv | 18 +
 rtl/multi_channel_sense_filter_if.sv | 25 ++
 rtl/multi_channel_sense_filter_channel.sv | 136 +++++++++++++
 rtl/multi_channel_sense_filter.sv | 46 ++++
 tb/tb_multi_channel_sense_filter.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/multi_channel_sense_filter_pkg.sv
// Shared types for the sense-event qualifier: programmable window and channel state.
package clks_alot_p;

  localparam int unsigned COUNTER_WIDTH = 8;

  typedef struct packed {
    logic [COUNTER_WIDTH-1:0] early_limit;
    logic [COUNTER_WIDTH-1:0] late_limit;
  } sense_window_s;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED,
    FAULT
  } sense_state_e;

endpackage

// File: rtl/multi_channel_sense_filter_if.sv
// Per-channel control and status bundle between edge-sense logic and the qualifier.
interface multi_channel_sense_filter_if #(
  parameter int unsigned WIDTH = 1
);

  logic [WIDTH-1:0] enable;
  logic [WIDTH-1:0] clear;
  logic [WIDTH-1:0] sense_event;
  logic [WIDTH-1:0] filtered_event;
  logic [WIDTH-1:0] over_freq;
  logic [WIDTH-1:0] under_freq;
  logic [WIDTH-1:0] locked;
  logic [WIDTH-1:0] fault;

  modport master (
    output enable, clear, sense_event,
    input  filtered_event, over_freq, under_freq, locked, fault
  );

  modport slave (
    input  enable, clear, sense_event,
    output filtered_event, over_freq, under_freq, locked, fault
  );

endinterface

// File: rtl/multi_channel_sense_filter_channel.sv
// One sense channel: interval counter, arming, event classification and lock/fault FSM.
module sense_filter_channel #(
  parameter int unsigned COUNTER_WIDTH = clks_alot_p::COUNTER_WIDTH,
  parameter int unsigned LOCK_COUNT    = 3,
  parameter int unsigned FAULT_COUNT   = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  clks_alot_p::sense_window_s window_i,
  multi_channel_sense_filter_if.slave ch
);

  import clks_alot_p::*;

  localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BW = $clog2(FAULT_COUNT + 1);

  sense_state_e st_q, st_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [GW-1:0] good_q, good_d, good_inc;
  logic [BW-1:0] bad_q, bad_d, bad_inc;
  logic armed_q, armed_d;
  logic filt_q, filt_d, over_q, over_d, under_q, under_d;
  logic locked_q, locked_d, fault_q, fault_d;
  logic active, early_hit, ref_ev, arm_ev, is_early, is_good, is_late, viol;

  always_comb begin
    active    = ch.enable[0] && (st_q != IDLE);
    // An inverted window makes every armed event early.
    early_hit = (cnt_q < window_i.early_limit) || (window_i.early_limit > window_i.late_limit);
    ref_ev    = active && ch.sense_event[0] && !armed_q;
    arm_ev    = active && ch.sense_event[0] && armed_q;
    is_early  = arm_ev && early_hit;
    is_good   = arm_ev && !early_hit && (cnt_q <= window_i.late_limit);
    is_late   = active && armed_q && !is_early && !is_good && (cnt_q >= window_i.late_limit);
    viol      = is_early || is_late;
    good_inc  = good_q + 1'b1;
    bad_inc   = (bad_q == BW'(FAULT_COUNT)) ? bad_q : bad_q + 1'b1;

    st_d    = st_q;
    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    armed_d = armed_q;
    good_d  = good_q;
    bad_d   = bad_q;
    filt_d  = 1'b0;
    over_d  = is_early;
    under_d = is_late;

    if (ref_ev || is_good) cnt_d = '0;
    if (ref_ev) armed_d = 1'b1;
    if (is_late) armed_d = 1'b0;

    case (st_q)
      IDLE: begin
        st_d  = ACQUIRE;
        cnt_d = '0;
      end
      ACQUIRE: begin
        if (viol) begin
          good_d = '0;
        end else if (is_good) begin
          if (good_inc == GW'(LOCK_COUNT)) begin
            st_d   = LOCKED;
            good_d = '0;
            bad_d  = '0;
          end else begin
            good_d = good_inc;
          end
        end
      end
      LOCKED: begin
        if (is_good) begin
          filt_d = 1'b1;
          bad_d  = '0;
        end else if (viol) begin
          bad_d = bad_inc;
          if (bad_inc == BW'(FAULT_COUNT)) st_d = FAULT;
        end
      end
      FAULT: begin
        if (ch.clear[0]) begin
          st_d    = ACQUIRE;
          cnt_d   = '0;
          armed_d = 1'b0;
          good_d  = '0;
          bad_d   = '0;
        end
      end
      default: st_d = IDLE;
    endcase

    if (!ch.enable[0]) begin
      st_d    = IDLE;
      cnt_d   = '0;
      armed_d = 1'b0;
      good_d  = '0;
      bad_d   = '0;
    end

    locked_d = (st_d == LOCKED);
    fault_d  = (st_d == FAULT);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      st_q     <= IDLE;
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      good_q   <= '0;
      bad_q    <= '0;
      filt_q   <= 1'b0;
      over_q   <= 1'b0;
      under_q  <= 1'b0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      filt_q   <= filt_d;
      over_q   <= over_d;
      under_q  <= under_d;
      locked_q <= locked_d;
      fault_q  <= fault_d;
    end
  end

  assign ch.filtered_event = filt_q;
  assign ch.over_freq      = over_q;
  assign ch.under_freq     = under_q;
  assign ch.locked         = locked_q;
  assign ch.fault          = fault_q;

endmodule

// File: rtl/multi_channel_sense_filter.sv
// Array of independent sense-filter channels sharing one programmable window.
module multi_channel_sense_filter #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned COUNTER_WIDTH = clks_alot_p::COUNTER_WIDTH,
  parameter int unsigned LOCK_COUNT    = 3,
  parameter int unsigned FAULT_COUNT   = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  clks_alot_p::sense_window_s window_i,
  input  logic [CHANNELS-1:0]        enable_i,
  input  logic [CHANNELS-1:0]        clear_i,
  input  logic [CHANNELS-1:0]        sense_event_i,
  output logic [CHANNELS-1:0]        filtered_event_o,
  output logic [CHANNELS-1:0]        over_frequency_violation_o,
  output logic [CHANNELS-1:0]        under_frequency_violation_o,
  output logic [CHANNELS-1:0]        locked_o,
  output logic [CHANNELS-1:0]        fault_o
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    multi_channel_sense_filter_if #(.WIDTH(1)) ch_if ();

    assign ch_if.enable      = enable_i[g];
    assign ch_if.clear       = clear_i[g];
    assign ch_if.sense_event = sense_event_i[g];

    assign filtered_event_o[g]            = ch_if.filtered_event[0];
    assign over_frequency_violation_o[g]  = ch_if.over_freq[0];
    assign under_frequency_violation_o[g] = ch_if.under_freq[0];
    assign locked_o[g]                    = ch_if.locked[0];
    assign fault_o[g]                     = ch_if.fault[0];

    sense_filter_channel #(
      .COUNTER_WIDTH(COUNTER_WIDTH),
      .LOCK_COUNT   (LOCK_COUNT),
      .FAULT_COUNT  (FAULT_COUNT)
    ) u_ch (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .window_i(window_i),
      .ch      (ch_if)
    );
  end

endmodule

// File: tb/tb_multi_channel_sense_filter.sv
// Directed vector bench for the two-channel sense filter with window 8..12.
module tb_multi_channel_sense_filter;

  localparam logic [1:0] Z  = 2'b00;
  localparam logic [1:0] C0 = 2'b01;
  localparam logic [1:0] C1 = 2'b10;
  localparam logic [1:0] CB = 2'b11;

  typedef struct {
    int         gap;
    logic [1:0] en;
    logic [1:0] clr;
    logic [1:0] ev;
    logic [1:0] filt;
    logic [1:0] over;
    logic [1:0] under;
    logic [1:0] lock;
    logic [1:0] flt;
  } vec_t;

  logic clk_i = 1'b0;
  logic rst_n_i;
  clks_alot_p::sense_window_s window;
  int n_total = 0;
  int n_bad   = 0;
  vec_t vecs[$];

  multi_channel_sense_filter_if #(.WIDTH(2)) tb_if ();

  multi_channel_sense_filter #(
    .CHANNELS     (2),
    .COUNTER_WIDTH(8),
    .LOCK_COUNT   (3),
    .FAULT_COUNT  (2)
  ) dut (
    .clk_i                      (clk_i),
    .rst_n_i                    (rst_n_i),
    .window_i                   (window),
    .enable_i                   (tb_if.enable),
    .clear_i                    (tb_if.clear),
    .sense_event_i              (tb_if.sense_event),
    .filtered_event_o           (tb_if.filtered_event),
    .over_frequency_violation_o (tb_if.over_freq),
    .under_frequency_violation_o(tb_if.under_freq),
    .locked_o                   (tb_if.locked),
    .fault_o                    (tb_if.fault)
  );

  always #5 clk_i = ~clk_i;

  function automatic vec_t mk(int gap, logic [1:0] en, logic [1:0] clr, logic [1:0] ev,
                              logic [1:0] filt, logic [1:0] over, logic [1:0] under,
                              logic [1:0] lock, logic [1:0] flt);
    vec_t v;
    v.gap = gap; v.en = en; v.clr = clr; v.ev = ev;
    v.filt = filt; v.over = over; v.under = under; v.lock = lock; v.flt = flt;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [1:0] got, input logic [1:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %b want %b at %0t", nm, idx, got, want, $time);
    end
  endtask

  task automatic cycle(input logic [1:0] en, input logic [1:0] clr, input logic [1:0] ev);
    @(negedge clk_i);
    tb_if.enable      = en;
    tb_if.clear       = clr;
    tb_if.sense_event = ev;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all(input string nm, input int idx, input vec_t v);
    chk({nm, "_filt"},  idx, tb_if.filtered_event, v.filt);
    chk({nm, "_over"},  idx, tb_if.over_freq,      v.over);
    chk({nm, "_under"}, idx, tb_if.under_freq,     v.under);
    chk({nm, "_lock"},  idx, tb_if.locked,         v.lock);
    chk({nm, "_fault"}, idx, tb_if.fault,          v.flt);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      for (int k = 1; k < vecs[i].gap; k++) cycle(vecs[i].en, Z, Z);
      cycle(vecs[i].en, vecs[i].clr, vecs[i].ev);
      chk_all("vec", i, vecs[i]);
    end
  endtask

  initial begin
    // Lock ch0 at period 10, then window boundaries.
    vecs.push_back(mk(2,  C0, Z, C0, Z,  Z,  Z, Z,  Z));   // 0 reference
    vecs.push_back(mk(10, C0, Z, C0, Z,  Z,  Z, Z,  Z));
    vecs.push_back(mk(10, C0, Z, C0, Z,  Z,  Z, Z,  Z));
    vecs.push_back(mk(10, C0, Z, C0, Z,  Z,  Z, C0, Z));   // 3 lock
    vecs.push_back(mk(10, C0, Z, C0, C0, Z,  Z, C0, Z));
    vecs.push_back(mk(10, C0, Z, C0, C0, Z,  Z, C0, Z));
    vecs.push_back(mk(4,  C0, Z, C0, Z,  C0, Z, C0, Z));   // 6 early
    vecs.push_back(mk(6,  C0, Z, C0, C0, Z,  Z, C0, Z));   // 7 in-band, bad cleared
    vecs.push_back(mk(4,  C0, Z, C0, Z,  C0, Z, C0, Z));   // 8 early, still locked
    vecs.push_back(mk(6,  C0, Z, C0, C0, Z,  Z, C0, Z));
    vecs.push_back(mk(9,  C0, Z, C0, C0, Z,  Z, C0, Z));   // 10 c==early
    vecs.push_back(mk(8,  C0, Z, C0, Z,  C0, Z, C0, Z));   // 11 c==early-1
    vecs.push_back(mk(1,  C0, Z, C0, C0, Z,  Z, C0, Z));   // 12 counter kept running
    vecs.push_back(mk(13, C0, Z, C0, C0, Z,  Z, C0, Z));   // 13 c==late
    // After timeout + reference: fault then clear and relock.
    vecs.push_back(mk(10, C0, Z,  C0, C0, Z,  Z, C0, Z));  // 14
    vecs.push_back(mk(4,  C0, Z,  C0, Z,  C0, Z, C0, Z));
    vecs.push_back(mk(4,  C0, Z,  C0, Z,  C0, Z, Z,  C0)); // 16 fault
    vecs.push_back(mk(2,  C0, Z,  C0, Z,  Z,  Z, Z,  C0)); // 17 suppressed
    vecs.push_back(mk(3,  C0, C0, Z,  Z,  Z,  Z, Z,  Z));  // 18 clear
    vecs.push_back(mk(2,  C0, Z,  C0, Z,  Z,  Z, Z,  Z));
    vecs.push_back(mk(10, C0, Z,  C0, Z,  Z,  Z, Z,  Z));
    vecs.push_back(mk(10, C0, Z,  C0, Z,  Z,  Z, Z,  Z));
    vecs.push_back(mk(10, C0, Z,  C0, Z,  Z,  Z, C0, Z));  // 22 relock
    vecs.push_back(mk(10, C0, Z,  C0, C0, Z,  Z, C0, Z));
    // ch1 at period 5 alongside ch0 at period 10.
    vecs.push_back(mk(5, CB, Z, C1, Z,  Z,  Z, C0, Z));    // 24
    vecs.push_back(mk(5, CB, Z, CB, C0, C1, Z, C0, Z));
    vecs.push_back(mk(5, CB, Z, C1, Z,  Z,  Z, C0, Z));
    vecs.push_back(mk(5, CB, Z, CB, C0, C1, Z, C0, Z));
    vecs.push_back(mk(5, CB, Z, C1, Z,  Z,  Z, C0, Z));
    vecs.push_back(mk(5, CB, Z, CB, C0, C1, Z, C0, Z));    // 29
    // After async reset: reference, relock, then disable with event.
    vecs.push_back(mk(2,  C0, Z, C0, Z,  Z, Z, Z,  Z));    // 30
    vecs.push_back(mk(10, C0, Z, C0, Z,  Z, Z, Z,  Z));
    vecs.push_back(mk(10, C0, Z, C0, Z,  Z, Z, Z,  Z));
    vecs.push_back(mk(10, C0, Z, C0, Z,  Z, Z, C0, Z));
    vecs.push_back(mk(10, C0, Z, C0, C0, Z, Z, C0, Z));
    vecs.push_back(mk(1,  Z,  Z, C0, Z,  Z, Z, Z,  Z));    // 35 disable wins
    vecs.push_back(mk(3,  C0, Z, C0, Z,  Z, Z, Z,  Z));

    window.early_limit = 8'd8;
    window.late_limit  = 8'd12;
    tb_if.enable      = Z;
    tb_if.clear       = Z;
    tb_if.sense_event = Z;
    rst_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk_all("reset", 0, mk(0, Z, Z, Z, Z, Z, Z, Z, Z));
    @(negedge clk_i);
    rst_n_i = 1'b1;

    run_vecs(0, 13);

    // Events stop: one under pulse 13 cycles after the last accepted event.
    for (int k = 1; k <= 16; k++) begin
      cycle(C0, Z, Z);
      chk("timeout_under", k, tb_if.under_freq, (k == 13) ? C0 : Z);
      chk("timeout_filt", k, tb_if.filtered_event, Z);
    end
    cycle(C0, Z, C0);
    chk_all("post_timeout_ref", 0, mk(0, Z, Z, Z, Z, Z, Z, C0, Z));

    run_vecs(14, 29);

    // Asynchronous reset while ch0 is locked and pulsing.
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("async_rst_filt", 0, tb_if.filtered_event, Z);
    chk("async_rst_over", 0, tb_if.over_freq, Z);
    chk("async_rst_lock", 0, tb_if.locked, Z);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    run_vecs(30, 36);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
